// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 host types, error codes and command bytes

package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_START,
      ST_WAIT_FIRST,
      ST_SEND,
      ST_ACK,
      ST_WAIT_IDLE,
      ST_ERR
   } ps2_state_t;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_START_TO = 2'b01;
   localparam logic [1:0] ERR_XFER_TO  = 2'b10;
   localparam logic [1:0] ERR_NO_ACK   = 2'b11;

   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] CMD_SET_RATE = 8'hF3;
   localparam logic [7:0] ACK_BYTE     = 8'hFA;

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - 2-FF synchroniser plus level filter for one PS/2 line

module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level
);

   localparam int             CW       = $clog2(FILTER_LEN + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_LEN - 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   // Idle bus is high, so everything resets to 1 to avoid a false edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync  <= 2'b11;
         cnt   <= '0;
         level <= 1'b1;
      end else begin
         sync <= {sync[0], raw};
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= sync[1];
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter

module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYC       = 12000,
   parameter int START_HOLD_CYC    = 200,
   parameter int START_TIMEOUT_CYC = 1500000,
   parameter int XFER_TIMEOUT_CYC  = 200000,
   parameter int FILTER_LEN        = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_err,
   output logic [1:0] err_code,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam logic [20:0] INH_LAST   = 21'(INHIBIT_CYC - 1);
   localparam logic [20:0] HOLD_LAST  = 21'(START_HOLD_CYC - 1);
   localparam logic [20:0] START_LAST = 21'(START_TIMEOUT_CYC - 1);
   localparam logic [17:0] XFER_LAST  = 18'(XFER_TIMEOUT_CYC - 1);

   logic       clk_f;
   logic       data_f;
   logic       clk_f_q;
   logic       clk_fall;

   ps2_state_t  state;
   logic [7:0]  shreg;
   logic        par;
   logic [3:0]  bit_idx;
   logic [20:0] phase_tmr;
   logic [17:0] xfer_tmr;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
      .clk   (clk),
      .rst   (rst),
      .raw   (ps2_clk_in),
      .level (clk_f)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
      .clk   (clk),
      .rst   (rst),
      .raw   (ps2_data_in),
      .level (data_f)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) clk_f_q <= 1'b1;
      else      clk_f_q <= clk_f;
   end

   assign clk_fall = clk_f_q & ~clk_f;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         shreg       <= '0;
         par         <= 1'b0;
         bit_idx     <= '0;
         phase_tmr   <= '0;
         xfer_tmr    <= '0;
         tx_ready    <= 1'b1;
         tx_busy     <= 1'b0;
         tx_done     <= 1'b0;
         tx_err      <= 1'b0;
         err_code    <= ERR_NONE;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         tx_err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (tx_valid) begin
                  shreg       <= tx_data;
                  par         <= ~^tx_data;
                  bit_idx     <= '0;
                  err_code    <= ERR_NONE;
                  phase_tmr   <= '0;
                  ps2_clk_oe  <= 1'b1;
                  ps2_data_oe <= 1'b0;
                  tx_ready    <= 1'b0;
                  tx_busy     <= 1'b1;
                  state       <= ST_INHIBIT;
               end
            end
            ST_INHIBIT: begin
               if (phase_tmr == INH_LAST) begin
                  phase_tmr   <= '0;
                  ps2_data_oe <= 1'b1;
                  state       <= ST_START;
               end else begin
                  phase_tmr <= phase_tmr + 1'b1;
               end
            end
            ST_START: begin
               if (phase_tmr == HOLD_LAST) begin
                  phase_tmr  <= '0;
                  ps2_clk_oe <= 1'b0;
                  state      <= ST_WAIT_FIRST;
               end else begin
                  phase_tmr <= phase_tmr + 1'b1;
               end
            end
            ST_WAIT_FIRST: begin
               // Expiry is checked first so it beats a coincident edge.
               if (phase_tmr == START_LAST) begin
                  err_code    <= ERR_START_TO;
                  tx_err      <= 1'b1;
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b0;
                  state       <= ST_ERR;
               end else begin
                  phase_tmr <= phase_tmr + 1'b1;
                  if (clk_fall) begin
                     ps2_data_oe <= ~shreg[0];
                     bit_idx     <= 4'd1;
                     xfer_tmr    <= '0;
                     state       <= ST_SEND;
                  end
               end
            end
            ST_SEND, ST_ACK, ST_WAIT_IDLE: begin
               if (xfer_tmr == XFER_LAST) begin
                  err_code    <= ERR_XFER_TO;
                  tx_err      <= 1'b1;
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b0;
                  state       <= ST_ERR;
               end else begin
                  xfer_tmr <= xfer_tmr + 1'b1;
                  if (state == ST_SEND && clk_fall) begin
                     if (bit_idx < 4'd8) begin
                        ps2_data_oe <= ~shreg[bit_idx[2:0]];
                        bit_idx     <= bit_idx + 1'b1;
                     end else if (bit_idx == 4'd8) begin
                        ps2_data_oe <= ~par;
                        bit_idx     <= 4'd9;
                     end else begin
                        ps2_data_oe <= 1'b0;
                        bit_idx     <= 4'd10;
                        state       <= ST_ACK;
                     end
                  end else if (state == ST_ACK && clk_fall) begin
                     if (!data_f) begin
                        state <= ST_WAIT_IDLE;
                     end else begin
                        err_code <= ERR_NO_ACK;
                        tx_err   <= 1'b1;
                        state    <= ST_ERR;
                     end
                  end else if (state == ST_WAIT_IDLE && clk_f && data_f) begin
                     tx_done  <= 1'b1;
                     tx_ready <= 1'b1;
                     tx_busy  <= 1'b0;
                     state    <= ST_IDLE;
                  end
               end
            end
            ST_ERR: begin
               tx_ready <= 1'b1;
               tx_busy  <= 1'b0;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model

module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int I    = 120;
   localparam int H    = 20;
   localparam int T    = 2000;
   localparam int X    = 2000;
   localparam int F    = 8;
   localparam int HALF = 30;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] tx_data = '0;
   logic       tx_valid = 1'b0;
   logic       tx_ready, tx_busy, tx_done, tx_err;
   logic [1:0] err_code;
   logic       ps2_clk_oe, ps2_data_oe;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;
   logic       ps2_clk_line, ps2_data_line;

   assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;
   int acc_cyc = 0;
   int err_cyc = 0;
   int first_fall_cyc = 0;
   int inhibit_len, hold_len;
   logic [10:0] rx_bits;

   ps2_host_tx #(
      .INHIBIT_CYC(I), .START_HOLD_CYC(H), .START_TIMEOUT_CYC(T),
      .XFER_TIMEOUT_CYC(X), .FILTER_LEN(F)
   ) dut (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err),
      .err_code(err_code), .ps2_clk_in(ps2_clk_line), .ps2_data_in(ps2_data_line),
      .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (tx_done) done_cnt <= done_cnt + 1;
      if (tx_err) begin
         err_cnt <= err_cnt + 1;
         err_cyc <= cyc;
      end
      if (tx_done && tx_err) both_cnt <= both_cnt + 1;
      if (tx_valid && tx_ready && rst) acc_cyc <= cyc;
   end

   // Reference frame: start 0, data LSB first, odd parity, stop 1.
   function automatic logic [10:0] frame_of(input logic [7:0] b);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic wait_rts(output bit ok);
      int n = 0;
      inhibit_len = 0;
      hold_len    = 0;
      while (!ps2_clk_oe && n < 50) begin @(negedge clk); n++; end
      n = 0;
      while (ps2_clk_oe && n < I + H + 50) begin
         if (ps2_data_oe) hold_len++;
         else inhibit_len++;
         @(negedge clk);
         n++;
      end
      ok = (inhibit_len > 0) && !ps2_clk_oe;
      rx_bits[0] = ps2_data_line;
   endtask

   task automatic dev_pulse(input int k);
      dev_clk_low = 1'b1;
      if (k == 1) first_fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k <= 10) rx_bits[k] = ps2_data_line;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic device_xfer(input int n_edges, input bit ack_ok);
      bit ok;
      rx_bits = '1;
      wait_rts(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rts_seen: inhibit=%0d hold=%0d, required request-to-send", inhibit_len, hold_len);
         return;
      end
      repeat (40) @(negedge clk);
      for (int k = 1; k <= n_edges; k++) begin
         if (k == 11) begin
            dev_data_low = ack_ok;
            repeat (5) @(negedge clk);
         end
         dev_pulse(k);
      end
      dev_data_low = 1'b0;
   endtask

   task automatic wait_event(input int d0, input int e0, input int budget, output bit got);
      int n = 0;
      while (done_cnt == d0 && err_cnt == e0 && n < budget) begin @(negedge clk); n++; end
      got = (done_cnt != d0) || (err_cnt != e0);
      repeat (3) @(negedge clk);
   endtask

   task automatic full_send(input logic [7:0] b, input string name);
      int d0 = done_cnt;
      int e0 = err_cnt;
      bit got;
      send_byte(b);
      device_xfer(11, 1'b1);
      wait_event(d0, e0, 500, got);
      checks++;
      if (!got) begin errors++; $display("FAIL %s_timeout: no tx_done/tx_err seen", name); end
      checks++;
      if (rx_bits !== frame_of(b)) begin
         errors++;
         $display("FAIL %s_frame: got %b required %b", name, rx_bits, frame_of(b));
      end
      checks++;
      if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
         errors++;
         $display("FAIL %s_pulses: done=%0d err=%0d required 1 and 0", name, done_cnt - d0, err_cnt - e0);
      end
      checks++;
      if (err_code !== 2'b00 || tx_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_end: err_code=%b ready=%b required 00 and 1", name, err_code, tx_ready);
      end
   endtask

   task automatic test_reset;
      checks++;
      if ({tx_ready, tx_busy, tx_done, tx_err, err_code, ps2_clk_oe, ps2_data_oe} !== 8'b1000_0000) begin
         errors++;
         $display("FAIL reset_state: got %b required 10000000",
                  {tx_ready, tx_busy, tx_done, tx_err, err_code, ps2_clk_oe, ps2_data_oe});
      end
   endtask

   task automatic test_send_enable;
      full_send(CMD_ENABLE, "enable");
      checks++;
      if (inhibit_len !== I || hold_len !== H) begin
         errors++;
         $display("FAIL enable_phases: inhibit=%0d hold=%0d required %0d %0d", inhibit_len, hold_len, I, H);
      end
      checks++;
      if (rx_bits[9] !== 1'b0) begin errors++; $display("FAIL enable_parity: got %b required 0", rx_bits[9]); end
   endtask

   task automatic test_send_reset_cmd;
      full_send(CMD_RESET, "resetcmd");
      checks++;
      if (rx_bits[9] !== 1'b1) begin errors++; $display("FAIL resetcmd_parity: got %b required 1", rx_bits[9]); end
   endtask

   task automatic test_random_bytes;
      logic [7:0] b;
      for (int i = 0; i < 4; i++) begin
         b = (i == 0) ? ACK_BYTE : (i == 1) ? CMD_SET_RATE : 8'($urandom_range(0, 255));
         full_send(b, $sformatf("rand%0d", i));
      end
   endtask

   task automatic test_busy_ignore;
      int d0 = done_cnt;
      bit got;
      send_byte(8'h5A);
      for (int i = 0; i < 5; i++) begin
         tx_data  = 8'hA5;
         tx_valid = 1'b1;
         @(negedge clk);
         checks++;
         if (tx_ready !== 1'b0 || tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_flags: ready=%b busy=%b required 0 1", tx_ready, tx_busy);
         end
      end
      tx_valid = 1'b0;
      device_xfer(11, 1'b1);
      wait_event(d0, err_cnt, 500, got);
      checks++;
      if (rx_bits !== frame_of(8'h5A) || done_cnt - d0 !== 1) begin
         errors++;
         $display("FAIL busy_ignore: frame=%b done=%0d required %b and 1", rx_bits, done_cnt - d0, frame_of(8'h5A));
      end
      repeat (40) @(negedge clk);
      checks++;
      if (tx_busy !== 1'b0 || done_cnt - d0 !== 1) begin
         errors++;
         $display("FAIL busy_no_queue: busy=%b done=%0d required 0 and 1", tx_busy, done_cnt - d0);
      end
   endtask

   task automatic test_start_timeout;
      int e0 = err_cnt;
      bit got;
      bit ok;
      send_byte(CMD_ENABLE);
      wait_rts(ok);
      wait_event(done_cnt, e0, T + 200, got);
      checks++;
      if (!got || err_code !== 2'b01) begin
         errors++;
         $display("FAIL start_timeout_code: got=%0d code=%b required 01", got, err_code);
      end
      checks++;
      if (err_cyc - acc_cyc < I + H + T || err_cyc - acc_cyc > I + H + T + 2) begin
         errors++;
         $display("FAIL start_timeout_time: %0d cycles required %0d..%0d", err_cyc - acc_cyc, I + H + T, I + H + T + 2);
      end
      checks++;
      if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1) begin
         errors++;
         $display("FAIL start_timeout_lines: clk_oe=%b data_oe=%b ready=%b required 0 0 1", ps2_clk_oe, ps2_data_oe, tx_ready);
      end
   endtask

   task automatic test_xfer_timeout;
      int e0 = err_cnt;
      bit got;
      send_byte(CMD_ENABLE);
      device_xfer(5, 1'b1);
      wait_event(done_cnt, e0, X + 200, got);
      checks++;
      if (!got || err_code !== 2'b10 || err_cnt - e0 !== 1) begin
         errors++;
         $display("FAIL xfer_timeout_code: got=%0d code=%b errs=%0d required 10 once", got, err_code, err_cnt - e0);
      end
      checks++;
      if (err_cyc - first_fall_cyc < X || err_cyc - first_fall_cyc > X + F + 8) begin
         errors++;
         $display("FAIL xfer_timeout_time: %0d cycles required %0d..%0d", err_cyc - first_fall_cyc, X, X + F + 8);
      end
   endtask

   task automatic test_no_ack;
      int e0 = err_cnt;
      int d0 = done_cnt;
      bit got;
      send_byte(CMD_RESET);
      device_xfer(11, 1'b0);
      wait_event(d0, e0, 500, got);
      checks++;
      if (err_code !== 2'b11 || err_cnt - e0 !== 1 || done_cnt !== d0) begin
         errors++;
         $display("FAIL no_ack_code: code=%b errs=%0d dones=%0d required 11, 1, 0", err_code, err_cnt - e0, done_cnt - d0);
      end
      checks++;
      if (tx_ready !== 1'b1) begin errors++; $display("FAIL no_ack_ready: got %b required 1", tx_ready); end
      full_send(CMD_ENABLE, "after_noack");
   endtask

   task automatic test_reset_mid_send;
      int d0 = done_cnt;
      int e0 = err_cnt;
      bit ok;
      send_byte(CMD_SET_RATE);
      wait_rts(ok);
      repeat (40) @(negedge clk);
      for (int k = 1; k <= 3; k++) dev_pulse(k);
      dev_clk_low = 1'b1;
      repeat (HALF / 2) @(negedge clk);
      #3 rst = 1'b0;
      #1;
      checks++;
      if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
         errors++;
         $display("FAIL midreset_outputs: clk_oe=%b data_oe=%b ready=%b busy=%b required 0 0 1 0",
                  ps2_clk_oe, ps2_data_oe, tx_ready, tx_busy);
      end
      dev_clk_low = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (30) @(negedge clk);
      checks++;
      if (done_cnt !== d0 || err_cnt !== e0) begin
         errors++;
         $display("FAIL midreset_pulses: done=%0d err=%0d required 0 0", done_cnt - d0, err_cnt - e0);
      end
      full_send(CMD_ENABLE, "after_reset");
   endtask

   initial begin
      repeat (3) @(negedge clk);
      test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      test_send_enable;
      test_send_reset_cmd;
      test_random_bytes;
      test_busy_ignore;
      test_start_timeout;
      test_xfer_timeout;
      test_no_ack;
      test_reset_mid_send;
      checks++;
      if (both_cnt !== 0) begin errors++; $display("FAIL done_err_exclusive: %0d overlaps required 0", both_cnt); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
